// File: rtl/hostsystem_cpu_ocimem_arbiter.sv
// OCI debug RAM arbiter: serialises JTAG debug-slave ops and the CPU Avalon slave
// onto one RAM port; JTAG has fixed priority, CPU reads take three cycles.
module hostsystem_cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    output logic [31:0]       MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata
);
    typedef enum logic [1:0] {IDLE, JRD, CRD, CDONE} state_t;

    state_t            state;
    logic              pend;
    logic              pend_wr;
    logic [31:0]       pend_data;
    logic [ADDR_W-1:0] jaddr;

    logic       any_pulse, multi_pulse, issue, accept;
    logic [1:0] pulse_cnt;
    logic       unused_jdo;

    assign unused_jdo  = ^{jdo[37:36], jdo[1:0]};
    assign any_pulse   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign pulse_cnt   = 2'(take_action_ocimem_a) + 2'(take_action_ocimem_b)
                       + 2'(take_no_action_ocimem_a);
    assign multi_pulse = pulse_cnt > 2'd1;
    assign issue       = pend && (state == IDLE);
    // The slot frees up in the cycle it issues, so a pulse landing then is kept.
    assign accept      = !pend || issue;
    assign jtag_busy   = pend || (state == JRD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pend         <= 1'b0;
            pend_wr      <= 1'b0;
            pend_data    <= '0;
            jaddr        <= '0;
            jtag_overrun <= 1'b0;
            MonDReg      <= '0;
            avs_readdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend) begin
                        pend  <= 1'b0;
                        jaddr <= jaddr + 1'b1;
                        if (!pend_wr) state <= JRD;
                    end else if (avs_read && !avs_write) begin
                        state <= CRD;
                    end
                end
                JRD: begin
                    MonDReg <= ram_rdata;
                    state   <= IDLE;
                end
                CRD: begin
                    avs_readdata <= ram_rdata;
                    state        <= CDONE;
                end
                CDONE:   state <= IDLE;
                default: state <= IDLE;
            endcase

            // Capture after issue so a freshly accepted op overrides the slot clear
            // and an op-A address load overrides the post-issue increment.
            if (any_pulse && accept) begin
                if (take_action_ocimem_b) begin
                    pend      <= 1'b1;
                    pend_wr   <= 1'b1;
                    pend_data <= jdo[34:3];
                end else if (take_action_ocimem_a) begin
                    jaddr <= jdo[ADDR_W+1:2];
                    if (jdo[35]) begin
                        pend    <= 1'b1;
                        pend_wr <= 1'b0;
                    end
                end else begin
                    pend    <= 1'b1;
                    pend_wr <= 1'b0;
                end
            end

            if (multi_pulse || (any_pulse && !accept)) jtag_overrun <= 1'b1;
        end
    end

    always_comb begin
        ram_addr        = '0;
        ram_wdata       = '0;
        ram_be          = '0;
        ram_we          = 1'b0;
        avs_waitrequest = 1'b1;
        if (!reset) begin
            if (state == IDLE) begin
                if (pend) begin
                    ram_addr  = jaddr;
                    ram_wdata = pend_data;
                    ram_be    = 4'hF;
                    ram_we    = pend_wr;
                end else if (avs_write) begin
                    ram_addr        = avs_address;
                    ram_wdata       = avs_writedata;
                    ram_be          = avs_byteenable;
                    ram_we          = 1'b1;
                    avs_waitrequest = 1'b0;
                end else if (avs_read) begin
                    ram_addr = avs_address;
                    ram_be   = avs_byteenable;
                end
            end else if (state == CDONE) begin
                avs_waitrequest = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hostsystem_cpu_ocimem_arbiter.sv
// Self-checking bench for the OCI RAM arbiter: behavioural RAM plus scoreboard
// queues for CPU read data and JTAG read data.
module tb_hostsystem_cpu_ocimem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [37:0] jdo;
    logic [31:0] MonDReg;
    logic        jtag_busy, jtag_overrun;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic [31:0] mem [256];
    logic        init_mem;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] cq[$];
    logic [31:0] jq[$];

    always #5 clk = ~clk;

    hostsystem_cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .jdo(jdo), .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
    );

    // Synchronous RAM: read data one cycle after the address.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hDEAD0000 | 32'(i);
        end else if (ram_we) begin
            for (int k = 0; k < 4; k++)
                if (ram_be[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CPU read completion monitor
    always @(negedge clk) begin
        #2;
        if (!reset && avs_read && !avs_waitrequest) begin
            if (cq.size() == 0) chk("cpu_rd_unexpected", 1, 0);
            else chk("cpu_rd_data", avs_readdata, cq.pop_front());
        end
    end

    function automatic logic [37:0] jd_a(input logic [7:0] addr, input logic rd);
        logic [37:0] r;
        r = '0;
        r[9:2] = addr;
        r[35] = rd;
        return r;
    endfunction

    function automatic logic [37:0] jd_b(input logic [31:0] d);
        logic [37:0] r;
        r = '0;
        r[34:3] = d;
        return r;
    endfunction

    task automatic jop(input logic a, input logic b, input logic n, input logic [37:0] d);
        @(negedge clk);
        take_action_ocimem_a = a; take_action_ocimem_b = b; take_no_action_ocimem_a = n;
        jdo = d;
        @(negedge clk);
        take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    endtask

    // JTAG read: MonDReg visible three cycles after the pulse.
    task automatic jrd(input string tag, input logic a, input logic n, input logic [37:0] d,
                       input logic [31:0] exp);
        jq.push_back(exp);
        jop(a, 1'b0, n, d);
        #1 chk({tag, "_busy"}, jtag_busy, 1);
        @(negedge clk);
        @(negedge clk);
        #1 chk(tag, MonDReg, jq.pop_front());
        chk({tag, "_idle"}, jtag_busy, 0);
    endtask

    task automatic wait_jtag_idle(input string tag);
        int t = 0;
        while (jtag_busy && t < 12) begin
            @(negedge clk); #1; t++;
        end
        chk({tag, "_timeout"}, jtag_busy, 0);
    endtask

    // Uncontended CPU read with optional op-N pulses in its first cycles.
    task automatic cpu_read(input logic [7:0] addr, input logic [31:0] exp, input int npulse);
        cq.push_back(exp);
        @(negedge clk);
        avs_read = 1; avs_address = addr; avs_byteenable = 4'hF;
        take_no_action_ocimem_a = (npulse >= 1);
        #1 chk("cpu_rd_wr1", avs_waitrequest, 1);
        @(negedge clk);
        take_no_action_ocimem_a = (npulse >= 2);
        #1 chk("cpu_rd_wr2", avs_waitrequest, 1);
        @(negedge clk);
        take_no_action_ocimem_a = 0;
        #1 chk("cpu_rd_wr3", avs_waitrequest, 0);
        @(negedge clk);
        avs_read = 0;
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        avs_write = 1; avs_address = addr; avs_writedata = d; avs_byteenable = be;
        #1 chk("cpu_wr_wr", avs_waitrequest, 0);
        @(negedge clk);
        avs_write = 0;
    endtask

    initial begin
        reset = 1; init_mem = 1;
        take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
        jdo = '0; avs_address = '0; avs_read = 0; avs_write = 0;
        avs_writedata = '0; avs_byteenable = '0;
        repeat (3) @(negedge clk);
        #1 chk("rst_wr", avs_waitrequest, 1);
        chk("rst_we", ram_we, 0);
        init_mem = 0;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        #1 chk("rst_mond", MonDReg, 0);
        chk("rst_rdata", avs_readdata, 0);
        chk("rst_busy", jtag_busy, 0);
        chk("rst_ovr", jtag_overrun, 0);
        chk("rst_wr_idle", avs_waitrequest, 1);

        // JTAG stream: writes at 0x10.., then reads back
        jop(1, 0, 0, jd_a(8'h10, 0));
        jop(0, 1, 0, jd_b(32'hA));
        jop(0, 1, 0, jd_b(32'hB));
        jop(0, 1, 0, jd_b(32'hC));
        repeat (2) @(negedge clk);
        chk("st_mem10", mem[8'h10], 32'hA);
        chk("st_mem11", mem[8'h11], 32'hB);
        chk("st_mem12", mem[8'h12], 32'hC);
        jrd("st_jaddr13", 0, 1, '0, 32'hDEAD0013);
        jrd("st_rd0", 1, 0, jd_a(8'h10, 1), 32'hA);
        jrd("st_rd1", 0, 1, '0, 32'hB);
        jrd("st_rd2", 0, 1, '0, 32'hC);

        // Address wrap
        jop(1, 0, 0, jd_a(8'hFF, 0));
        jop(0, 1, 0, jd_b(32'h55));
        jop(0, 1, 0, jd_b(32'h66));
        repeat (2) @(negedge clk);
        chk("wrap_ff", mem[8'hFF], 32'h55);
        chk("wrap_00", mem[8'h00], 32'h66);

        // Contention: CPU write while an op B is pending (jaddr = 1)
        @(negedge clk);
        take_action_ocimem_b = 1; jdo = jd_b(32'h77);
        @(negedge clk);
        take_action_ocimem_b = 0;
        avs_write = 1; avs_address = 8'h20; avs_writedata = 32'h12345678; avs_byteenable = 4'hF;
        #1 chk("cont_wr1", avs_waitrequest, 1);
        chk("cont_jaddr", ram_addr, 8'h01);
        @(negedge clk);
        #1 chk("cont_wr2", avs_waitrequest, 0);
        chk("cont_caddr", ram_addr, 8'h20);
        @(negedge clk);
        avs_write = 0;
        @(negedge clk);
        chk("cont_jmem", mem[8'h01], 32'h77);
        chk("cont_cmem", mem[8'h20], 32'h12345678);

        // Partial byte-enable CPU write
        cpu_write(8'h21, 32'hAABBCCDD, 4'b0101);
        @(negedge clk);
        chk("be_mem", mem[8'h21], 32'hDEBB00DD);

        // CPU read with an op N arriving in its first cycle (jaddr = 2)
        cpu_read(8'h10, 32'hA, 1);
        wait_jtag_idle("crd_jn");
        chk("crd_jn_mond", MonDReg, 32'hDEAD0002);
        chk("crd_jn_ovr", jtag_overrun, 0);

        // Overrun: second op N lands while the first is held behind a CPU read
        cpu_read(8'h11, 32'hB, 2);
        chk("ovr_set", jtag_overrun, 1);
        wait_jtag_idle("ovr");
        chk("ovr_mond", MonDReg, 32'hDEAD0003);
        jrd("ovr_next", 0, 1, '0, 32'hDEAD0004);
        chk("ovr_sticky", jtag_overrun, 1);

        // Reset in the middle of a CPU read with a JTAG op pending
        @(negedge clk);
        avs_read = 1; avs_address = 8'h12; take_no_action_ocimem_a = 1;
        @(negedge clk);
        take_no_action_ocimem_a = 0;
        #1 chk("mid_busy_pre", jtag_busy, 1);
        reset = 1;
        @(negedge clk);
        #1 chk("mid_wr", avs_waitrequest, 1);
        chk("mid_rdata", avs_readdata, 0);
        chk("mid_busy", jtag_busy, 0);
        chk("mid_ovr", jtag_overrun, 0);
        avs_read = 0;
        @(negedge clk);
        reset = 0;

        // Simultaneous pulses: A beats N, B beats A
        jrd("pri_an", 1, 1, jd_a(8'h30, 1), 32'hDEAD0030);
        chk("pri_an_ovr", jtag_overrun, 1);
        jop(1, 1, 0, jd_b(32'hC0DE0400));
        repeat (2) @(negedge clk);
        chk("pri_ba_mem", mem[8'h31], 32'hC0DE0400);
        jrd("pri_ba_next", 0, 1, '0, 32'hDEAD0032);

        repeat (2) @(negedge clk);
        chk("cq_empty", cq.size(), 0);
        chk("jq_empty", jq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
